// File: rtl/snn_pkg.sv
// Shared definitions for the SNN phase sequencer and the population datapath:
// phase codes, default neuron count and the address-width helper.
package snn_pkg;

    localparam int unsigned N_NUM_DEF = 32;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'b000,
        PH_SET      = 3'b001,
        PH_SYN_ACCU = 3'b010,
        PH_DECAY    = 3'b011,
        PH_PDE      = 3'b100,
        PH_FINISH   = 3'b101,
        PH_DONE     = 3'b110
    } phase_e;

    // Bits needed to index n items; never less than 1.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/snn_pair_finder.sv
// Priority encoder: lowest neuron pair at or after cand_i whose two spike bits
// are not both zero. Used only when SKIP_ZERO_PAIR_EN is defined.
module snn_pair_finder
    import snn_pkg::*;
#(
    parameter int unsigned N_NUM = N_NUM_DEF
) (
    input  logic [N_NUM-1:0]          vec_i,
    input  logic [addr_w(N_NUM)-1:0]  cand_i,
    output logic                      found_o,
    output logic [addr_w(N_NUM)-1:0]  pair_o
);

    localparam int unsigned AW = addr_w(N_NUM);
    localparam int unsigned NP = N_NUM / 2;

    // Scan high to low so the last hit written is the lowest qualifying pair.
    always_comb begin
        found_o = 1'b0;
        pair_o  = '0;
        for (int unsigned k = NP; k > 0; k--) begin
            if ((k - 1) >= 32'(cand_i) && vec_i[2*(k-1) +: 2] != 2'b00) begin
                found_o = 1'b1;
                pair_o  = AW'(k - 1);
            end
        end
    end

endmodule

// File: rtl/snn_phase_sequencer.sv
// Timestep phase sequencer for a spiking-neuron population datapath.
// Optional feature: define SKIP_ZERO_PAIR_EN to skip all-zero neuron pairs.
module snn_phase_sequencer
    import snn_pkg::*;
#(
    parameter int unsigned N_NUM     = N_NUM_DEF,
    parameter int unsigned NUM_STEPS = 16,
    parameter int unsigned DECAY_CYC = 4,
    parameter int unsigned PDE_CYC   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      spike_vld,
    input  logic [N_NUM-1:0]          spike_vec,
    input  logic                      shift_en,
    output logic                      spike_rdy,
    output logic [2:0]                state,
    output logic [addr_w(N_NUM)-1:0]  rf_addr,
    output logic [1:0]                spike,
    output logic [7:0]                step_cnt,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned AW   = addr_w(N_NUM);
    localparam int unsigned MAXC = (DECAY_CYC > PDE_CYC) ? DECAY_CYC : PDE_CYC;
    localparam int unsigned CW   = addr_w(MAXC + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_NUM - 2);

    phase_e             state_q, state_d;
    logic               loaded_q, loaded_d;
    logic [N_NUM-1:0]   vec_q, vec_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         step_q, step_d;
    logic [7:0]         step_inc;
    logic               in_pair;

`ifdef SKIP_ZERO_PAIR_EN
    logic [N_NUM-1:0]   pf_vec;
    logic [AW-1:0]      pf_cand;
    logic [AW-1:0]      pf_pair;
    logic               pf_found;

    // Before the load the search runs on the incoming vector from pair 0,
    // afterwards on the latched vector from the pair after the current one.
    assign pf_vec  = loaded_q ? vec_q : spike_vec;
    assign pf_cand = loaded_q ? (addr_q >> 1) + AW'(1) : '0;

    snn_pair_finder #(
        .N_NUM (N_NUM)
    ) u_pair_finder (
        .vec_i   (pf_vec),
        .cand_i  (pf_cand),
        .found_o (pf_found),
        .pair_o  (pf_pair)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PH_IDLE;
            loaded_q <= 1'b0;
            vec_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            vec_q    <= vec_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        vec_d    = vec_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        step_inc = step_q + 8'd1;
        unique case (state_q)
            PH_IDLE: begin
                if (start) begin
                    state_d = PH_SET;
                    step_d  = '0;
                end
            end
            PH_SET: begin
                state_d  = PH_SYN_ACCU;
                loaded_d = 1'b0;
            end
            PH_SYN_ACCU: begin
                if (!loaded_q) begin
                    if (spike_vld) begin
                        vec_d    = spike_vec;
                        loaded_d = 1'b1;
`ifdef SKIP_ZERO_PAIR_EN
                        addr_d = pf_pair << 1;
                        if (!pf_found) begin
                            state_d = PH_DECAY;
                            cnt_d   = CW'(DECAY_CYC - 1);
                        end
`else
                        addr_d = '0;
`endif
                    end
                end else if (shift_en) begin
`ifdef SKIP_ZERO_PAIR_EN
                    if (pf_found) begin
                        addr_d = pf_pair << 1;
                    end else begin
                        state_d = PH_DECAY;
                        cnt_d   = CW'(DECAY_CYC - 1);
                    end
`else
                    if (addr_q == LAST_ADDR) begin
                        state_d = PH_DECAY;
                        cnt_d   = CW'(DECAY_CYC - 1);
                    end else begin
                        addr_d = addr_q + AW'(2);
                    end
`endif
                end
            end
            PH_DECAY: begin
                if (cnt_q == '0) begin
                    state_d = PH_PDE;
                    cnt_d   = CW'(PDE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PH_PDE: begin
                if (cnt_q == '0) begin
                    state_d = PH_FINISH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PH_FINISH: begin
                step_d   = step_inc;
                loaded_d = 1'b0;
                state_d  = (step_inc == 8'(NUM_STEPS)) ? PH_DONE : PH_SYN_ACCU;
            end
            PH_DONE: begin
                state_d = PH_IDLE;
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    always_comb begin
        in_pair   = (state_q == PH_SYN_ACCU) && loaded_q;
        spike_rdy = (state_q == PH_SYN_ACCU) && !loaded_q;
        rf_addr   = in_pair ? addr_q : '0;
        spike     = in_pair ? vec_q[addr_q +: 2] : 2'b00;
        state     = state_q;
        step_cnt  = step_q;
        busy      = (state_q != PH_IDLE);
        done      = (state_q == PH_DONE);
    end

endmodule

// File: tb/tb_snn_phase_sequencer.sv
// Randomized self-checking bench for snn_phase_sequencer against a phase-level
// reference model (honours SKIP_ZERO_PAIR_EN the same way the design does).
module tb_snn_phase_sequencer;

    localparam int N  = 32;
    localparam int NS = 3;
    localparam int DC = 4;
    localparam int PC = 4;
    localparam int NP = N / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        spike_vld;
    logic [31:0] spike_vec;
    logic        shift_en;
    logic        spike_rdy;
    logic [2:0]  state;
    logic [4:0]  rf_addr;
    logic [1:0]  spike;
    logic [7:0]  step_cnt;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase number 0..6, cycles left in timed phases.
    int          m_phase;
    int          m_pair;
    int          m_left;
    int          m_step;
    bit          m_loaded;
    logic [31:0] m_vec;

    snn_phase_sequencer #(
        .N_NUM     (N),
        .NUM_STEPS (NS),
        .DECAY_CYC (DC),
        .PDE_CYC   (PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .spike_vld (spike_vld),
        .spike_vec (spike_vec),
        .shift_en  (shift_en),
        .spike_rdy (spike_rdy),
        .state     (state),
        .rf_addr   (rf_addr),
        .spike     (spike),
        .step_cnt  (step_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_pair(input logic [31:0] v, input int cand);
        for (int p = cand; p < NP; p++) begin
`ifdef SKIP_ZERO_PAIR_EN
            if (((v >> (2 * p)) & 32'd3) != 32'd0) return p;
`else
            return p;
`endif
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_pair   = 0;
        m_left   = 0;
        m_step   = 0;
        m_loaded = 1'b0;
        m_vec    = '0;
    endtask

    task automatic model_clock(input bit st, input bit vld, input logic [31:0] v, input bit sh);
        case (m_phase)
            0: if (st) begin m_phase = 1; m_step = 0; end
            1: begin m_phase = 2; m_loaded = 1'b0; end
            2: begin
                if (!m_loaded) begin
                    if (vld) begin
                        m_vec    = v;
                        m_loaded = 1'b1;
                        m_pair   = next_pair(v, 0);
                    end
                end else if (sh) begin
                    m_pair = next_pair(m_vec, m_pair + 1);
                end
                if (m_loaded && m_pair < 0) begin
                    m_phase = 3;
                    m_left  = DC;
                end
            end
            3: begin
                m_left--;
                if (m_left == 0) begin m_phase = 4; m_left = PC; end
            end
            4: begin
                m_left--;
                if (m_left == 0) m_phase = 5;
            end
            5: begin
                m_step++;
                m_loaded = 1'b0;
                m_phase  = (m_step == NS) ? 6 : 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_outputs();
        bit in_pair;
        in_pair = (m_phase == 2) && m_loaded;
        check_eq("state",     32'(state),     32'(m_phase));
        check_eq("busy",      32'(busy),      32'(m_phase != 0));
        check_eq("done",      32'(done),      32'(m_phase == 6));
        check_eq("spike_rdy", 32'(spike_rdy), 32'((m_phase == 2) && !m_loaded));
        check_eq("rf_addr",   32'(rf_addr),   in_pair ? 32'(2 * m_pair) : 32'd0);
        check_eq("spike",     32'(spike),     in_pair ? ((m_vec >> (2 * m_pair)) & 32'd3) : 32'd0);
        check_eq("step_cnt",  32'(step_cnt),  32'(m_step));
    endtask

    task automatic tick(input bit st, input bit vld, input logic [31:0] v, input bit sh);
        compare_outputs();
        start     = st;
        spike_vld = vld;
        spike_vec = v;
        shift_en  = sh;
        @(posedge clk);
        model_clock(st, vld, v, sh);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_vec();
        logic [31:0] r;
        case ($urandom_range(0, 4))
            0:       r = $urandom;
            1:       r = $urandom & $urandom & $urandom;
            2:       r = 32'h1 << $urandom_range(0, 31);
            3:       r = '0;
            default: r = '1;
        endcase
        return r;
    endfunction

    task automatic run_until_idle(input bit st_hold, input bit rnd, input logic [31:0] v, input int budget);
        int b;
        b = budget;
        while (m_phase != 0 && b > 0) begin
            if (rnd) tick(st_hold, $urandom_range(0, 2) == 0, rand_vec(), $urandom_range(0, 1) == 1);
            else     tick(st_hold, 1'b1, v, 1'b1);
            b--;
        end
        if (b == 0) check_eq("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int b;
        rst = 1'b1; start = 1'b0; spike_vld = 1'b0; spike_vec = '0; shift_en = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // All-ones vector, shift_en tied high: full multi-step run.
        tick(1'b1, 1'b0, '0, 1'b1);
        run_until_idle(1'b0, 1'b0, 32'hFFFF_FFFF, 400);
        repeat (3) tick(1'b0, 1'b1, '1, 1'b1);

        // Delayed load: spike_vld low for 5 SYN_ACCU cycles while shift_en is high.
        tick(1'b1, 1'b0, '0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        repeat (5) tick(1'b0, 1'b0, $urandom, 1'b1);
        tick(1'b0, 1'b1, 32'hA5A5_5A5A, 1'b0);
        run_until_idle(1'b0, 1'b1, '0, 1500);

        // Sparse vector, start held high throughout the busy period.
        tick(1'b1, 1'b0, '0, 1'b0);
        run_until_idle(1'b1, 1'b0, 32'h0000_0003, 400);

        // Asynchronous reset during PDE of the second step.
        tick(1'b1, 1'b0, '0, 1'b0);
        b = 400;
        while (!(m_phase == 4 && m_step == 1) && b > 0) begin
            tick(1'b0, 1'b1, rand_vec(), 1'b1);
            b--;
        end
        if (b == 0) check_eq("pde_timeout", 32'd0, 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_outputs();
        @(negedge clk);
        compare_outputs();
        rst = 1'b0;
        tick(1'b0, 1'b1, '1, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b1);
        run_until_idle(1'b0, 1'b0, 32'h8000_0001, 400);

        // Free-running random traffic.
        for (int i = 0; i < 2000; i++) begin
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, rand_vec(), $urandom_range(0, 1) == 1);
        end
        run_until_idle(1'b0, 1'b1, '0, 1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
